// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the iterative RV32M mul/div unit.
interface muldiv_unit_if;
  localparam int unsigned XLEN = 32;

  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, rs1_val, rs2_val,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, rs1_val, rs2_val,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide,
// one bit per cycle, fixed 34-cycle latency from the accepting edge to done.
module muldiv_unit (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned W2   = 2 * XLEN;
  localparam int unsigned CW   = 5;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    CALC = 2'd2,
    FIN  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [2:0]      op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0] mag_a_q, mag_b_q;
  logic [W2-1:0]   acc_q;
  logic [CW-1:0]   cnt_q;
  logic            neg_q;

  logic            busy_q, done_q;
  logic [XLEN-1:0] result_q;

  // Sign handling, computed from the captured operands during PREP
  logic            signed_a, signed_b, sign_a, sign_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            neg_res;

  // Restoring-divide step and multiply partial product
  logic [XLEN:0]   div_partial, div_diff;
  logic [W2-1:0]   mul_addend;

  // Final sign correction and output selection
  logic [W2-1:0]   prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix;
  logic [XLEN-1:0] fin_result;
  logic            div_by_zero;

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = PREP;
      PREP:    state_d = CALC;
      CALC:    if (cnt_q == CW'(XLEN - 1)) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    signed_a = (op_q == OP_MULH) || (op_q == OP_MULHSU) ||
               (op_q == OP_DIV)  || (op_q == OP_REM);
    signed_b = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
    sign_a   = signed_a && a_q[XLEN-1];
    sign_b   = signed_b && b_q[XLEN-1];
    mag_a    = sign_a ? (XLEN'(0) - a_q) : a_q;
    mag_b    = sign_b ? (XLEN'(0) - b_q) : b_q;
    // Remainder takes the dividend's sign; product and quotient take the XOR
    neg_res  = ((op_q == OP_REM) || (op_q == OP_REMU)) ? sign_a : (sign_a ^ sign_b);
  end

  always_comb begin
    div_partial = {acc_q[W2-1:XLEN], mag_a_q[XLEN-1]};
    div_diff    = div_partial - {1'b0, mag_b_q};
    mul_addend  = mag_b_q[cnt_q] ? (W2'(mag_a_q) << cnt_q) : W2'(0);
  end

  always_comb begin
    prod_fix    = neg_q ? (W2'(0) - acc_q) : acc_q;
    quo_fix     = neg_q ? (XLEN'(0) - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    rem_fix     = neg_q ? (XLEN'(0) - acc_q[W2-1:XLEN]) : acc_q[W2-1:XLEN];
    div_by_zero = (b_q == XLEN'(0));
    fin_result  = '0;
    case (op_q)
      OP_MUL:                      fin_result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_result = prod_fix[W2-1:XLEN];
      OP_DIV, OP_DIVU:             fin_result = div_by_zero ? '1 : quo_fix;
      OP_REM, OP_REMU:             fin_result = div_by_zero ? a_q : rem_fix;
      default:                     fin_result = '0;
    endcase
  end

  // Operand capture, iteration datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      busy_q <= (state_d != IDLE);
      done_q <= (state_q == FIN);
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            op_q <= bus.funct3;
            a_q  <= bus.rs1_val;
            b_q  <= bus.rs2_val;
          end
        end
        PREP: begin
          mag_a_q <= mag_a;
          mag_b_q <= mag_b;
          neg_q   <= neg_res;
          acc_q   <= '0;
          cnt_q   <= '0;
        end
        CALC: begin
          cnt_q <= cnt_q + CW'(1);
          if (op_q[2]) begin
            // acc holds {remainder, quotient}; dividend bits stream out of mag_a MSB-first
            mag_a_q <= mag_a_q << 1;
            if (!div_diff[XLEN]) begin
              acc_q <= {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
              acc_q <= {div_partial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end
          end else begin
            acc_q <= acc_q + mul_addend;
          end
        end
        FIN: begin
          result_q <= fin_result;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit sitting beside the ALU in the execute stage of the datapath. It consumes decoded rs1/rs2 operand values and funct3 for the eight M-extension instructions. It returns a 32-bit result to the writeback mux after a fixed multi-cycle latency. While it runs, `busy` is used by the datapath to hold the PC and suppress register write-enable.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while the unit is idle.
- funct3  input  3  operation select:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_val  input  32  operand A (multiplicand/dividend).
- rs2_val  input  32  operand B (multiplier/divisor).
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; `result` is valid in the same cycle.
- result  output  32  last completed result; held until the next `done`.

## Operation
- FSM states:
  - IDLE → PREP, on `start` while in IDLE.
  - PREP → CALC, always.
  - CALC → FIN, when the iteration counter reaches 31.
  - FIN → IDLE, always.
- Operand capture: `funct3`, `rs1_val` and `rs2_val` are registered on the accepting edge. Later input changes have no effect on the operation in flight.
- PREP:
  - Compute operand signs per op. Signed: MULH A and B, MULHSU A only, DIV/REM A and B.
  - Convert signed negatives to magnitudes.
  - Record result sign: product sign = signA XOR signB; quotient sign = signA XOR signB; remainder sign = signA.
  - Clear the 64-bit accumulator and the 5-bit counter.
- CALC: exactly 32 iterations, one per cycle.
  - Multiply: shift-add on unsigned magnitudes into a 64-bit product.
  - Divide: restoring division; 33-bit trial subtract, 32-bit quotient and remainder.
- FIN: apply sign correction (two's complement of the 64-bit product or of the 32-bit quotient/remainder), then select the output:
  - MUL: product[31:0].
  - MULH, MULHSU, MULHU: product[63:32].
  - DIV, DIVU: quotient.
  - REM, REMU: remainder.
- Divide by zero (B == 0), all four divide ops:
  - DIV, DIVU: 0xFFFFFFFF.
  - REM, REMU: A unchanged.
  - Resolved in FIN; latency is unchanged.
- Signed overflow (DIV/REM, A = 0x80000000, B = 0xFFFFFFFF): quotient 0x80000000, remainder 0.
- `start` while busy is ignored: no queuing, no error.
- `start` in the cycle `done` is high is accepted, because the FSM is already in IDLE.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0x00000000, state=IDLE, counter=0.
- Let E0 be the edge that samples `start`=1 in IDLE:
  - `busy` is high from E0 through E34 (PREP 1 cycle + CALC 32 cycles + FIN 1 cycle).
  - At E34 the FSM returns to IDLE, `busy` falls, `done` rises, and `result` updates.
- Latency is fixed at 34 cycles for every funct3 and every operand value, including the special cases.
- `done` is high for exactly one cycle. `busy` and `done` are never high together.
- `result` is registered and changes only at the edge that raises `done`, or on reset.
- Back-to-back: if `start` is high in the `done` cycle, the next `busy` period begins at the following edge.
- Reset mid-operation: `rst` high at any edge forces IDLE, `busy`=0, `done`=0 and `result`=0. The operation in flight is abandoned and no `done` is issued for it.
- `rst` and `start` high at the same edge: reset wins and the request is dropped.

## Test plan
- Multiply ops, `done` exactly 34 cycles after start in every case:
  - MUL, 7 × 0xFFFFFFFD → 0xFFFFFFEB.
  - MULH, 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU, 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU, 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Signed divide, A = 0xFFFFFFF9 (−7), B = 2:
  - DIV → 0xFFFFFFFD.
  - REM → 0xFFFFFFFF.
  - DIVU with the same operands → 0x7FFFFFFC.
- Special cases, each still with 34-cycle latency:
  - DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
- Handshake:
  - Operands changed and `start` pulsed again at cycle 5 of an op → ignored; original result returned.
  - `start` held high in the `done` cycle → second op completes exactly 35 cycles after the first `done`.
- Reset:
  - `rst` asserted 10 cycles into a DIV → next cycle `busy`=0, `done`=0, `result`=0; no `done` for the abandoned op.
  - New MUL 3 × 4 issued after reset → 0x0000000C.
- Hold: after `done`, idle for 20 cycles → `result` stable, `done` low throughout.
